vga_timing_ctrl: RTL
====================

Name: vga_timing_ctrl

Overview:
- Generates 640x480@60 Hz VGA timing: horizontal/vertical counters, active-low sync pulses, and the pixel coordinate bus consumed by vga_screen_pic.
- Samples the 12-bit colour returned by vga_screen_pic and drives the registered RGB pins, with sync aligned to the colour.
- Emits a one-cycle tick at vertical-blank entry so game_logic can update state outside the visible region.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)

Ports:
- clk  in  1  system clock; pixel clock (25 MHz) unless CLK_DIV_EN
- rst_n  in  1  asynchronous active-low reset
- rgb_in  in  12  colour from vga_screen_pic for current pix_x/pix_y; R[11:8] G[7:4] B[3:0]
- pix_x  out  10  current visible column, 0..639
- pix_y  out  9  current visible row, 0..479
- video_on  out  1  high while counters are in the visible region
- vga_r  out  4  registered red
- vga_g  out  4  registered green
- vga_b  out  4  registered blue
- hsync  out  1  registered, active-low
- vsync  out  1  registered, active-low
- vblank_tick  out  1  one-pixel-period pulse at vertical-blank entry

Behaviour:
- Line and frame totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800.
  - V_TOTAL = 525.
- Counters:
  - h_cnt is 10 bits and v_cnt is 10 bits.
  - Both advance on each pixel enable (pix_en); pix_en is constant 1 without CLK_DIV_EN.
  - h_cnt counts 0..799 and wraps to 0.
  - When h_cnt wraps, v_cnt increments, counting 0..524 and wrapping to 0.
  - Both wraps occurring together return the counters to (0,0). No frame is skipped.
- Visible region:
  - video_on is combinational: (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - pix_x = h_cnt when video_on, else 0.
  - pix_y = v_cnt[8:0] when video_on, else 0.
- Sync decode:
  - hsync_raw is low for h_cnt in [656, 751].
  - vsync_raw is low for v_cnt in [490, 491].
- Output pipeline (one stage, updated on pix_en):
  - vga_r/g/b <= video_on ? rgb_in : 0.
  - hsync <= hsync_raw and vsync <= vsync_raw.
  - Colour and sync therefore share exactly 1 pixel period of latency relative to the counters.
  - Colour outside the visible region is forced to 0, whatever rgb_in is.
- vblank_tick:
  - Registered.
  - High for exactly one pix_en period when the counters move to (h_cnt=0, v_cnt=480); otherwise 0.
  - Exactly one pulse per frame.
- Reset (asynchronous assert, synchronous release by the system):
  - h_cnt=0, v_cnt=0, vga_r/g/b=0, hsync=1, vsync=1, vblank_tick=0.
  - The CLK_DIV_EN divider also clears to 0.
  - Reset mid-frame restarts timing at (0,0) immediately, with no partial sync pulse held.
  - After release, the first pix_en advances h_cnt to 1.
- rgb_in has no handshake. It is sampled every pix_en and must settle combinationally within one clk.

Optional Feature:
- Macro: VGA_CLK_DIV_EN.
- Defined:
  - clk is 100 MHz.
  - A 2-bit free-running divider generates pix_en=1 when the divider equals 3, i.e. 1 in 4 clk cycles.
  - Counters, output registers and vblank_tick update only on pix_en.
  - vblank_tick stays high for 4 clk cycles (one pix_en period).
- Undefined:
  - No divider; pix_en is tied to 1 and clk must be 25 MHz.

Test Plan:
- Reset, then release and run 800 pix_en -> hsync low for exactly 96 pix_en periods, first low output period at counter 656 plus 1 latency; pix_x runs 0..639, then 0 during blanking.
- Run 1 full frame (420000 pix_en) -> vsync low for exactly 2 lines (1600 periods); vblank_tick pulses exactly once, when the counters reach (0,480); the frame restarts at (0,0).
- Drive rgb_in=12'hF70 constant -> vga_r=F, vga_g=7, vga_b=0 only in visible periods, lagging video_on by 1; 0 in blanking.
- Drive rgb_in=12'h00F while h_cnt in blanking (e.g. 700) -> RGB outputs stay 0.
- Assert rst_n=0 at h_cnt=300, v_cnt=200 for 3 cycles -> outputs reset asynchronously (hsync=vsync=1, RGB=0); after release, timing resumes from (0,0).
- With VGA_CLK_DIV_EN -> pix_x increments once every 4 clk cycles; vblank_tick high for 4 clk cycles; line period = 3200 clk cycles.

Source files
------------

// File: rtl/vga_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_ctrl
// Purpose  : 640x480@60 Hz VGA timing generator. Produces the horizontal and
//            vertical counters, the visible-pixel coordinate bus handed to the
//            picture generator, and registered RGB / sync outputs. The colour
//            and sync registers share one pixel period of latency, so the
//            pins stay mutually aligned. A one-pixel-period tick marks the
//            entry into vertical blanking so game state can be updated
//            outside the visible area.
//
// Ports    : clk          system clock (pixel clock unless divided)
//            rst_n        asynchronous active-low reset
//            rgb_in[11:0] colour for the current pix_x/pix_y, R[11:8] G[7:4] B[3:0]
//            pix_x[9:0]   visible column, 0 outside the visible region
//            pix_y[8:0]   visible row, 0 outside the visible region
//            video_on     counters are inside the visible region (combinational)
//            vga_r/g/b    registered colour, forced to 0 during blanking
//            hsync/vsync  registered, active-low sync pulses
//            vblank_tick  registered one-pixel-period pulse at blank entry
//
// Options  : `define VGA_CLK_DIV_EN  -> clk is 4x the pixel rate; a 2-bit
//            free-running divider produces a pixel enable every 4th clk.
//            Undefined (default): every clk is a pixel.
//
// Revision : 1.0  initial release
// ============================================================================
module vga_timing_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] rgb_in,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic        video_on,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        hsync,
    output logic        vsync,
    output logic        vblank_tick
);

    // ------------------------------------------------------------------------
    // Timing landmarks, sized to the 10-bit counters
    // ------------------------------------------------------------------------
    localparam logic [9:0] c_h_active     = 10'(H_ACTIVE);
    localparam logic [9:0] c_h_sync_start = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] c_h_sync_end   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] c_h_last       = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);

    localparam logic [9:0] c_v_active     = 10'(V_ACTIVE);
    localparam logic [9:0] c_v_last_vis   = 10'(V_ACTIVE - 1);
    localparam logic [9:0] c_v_sync_start = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] c_v_sync_end   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0] c_v_last       = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic        w_pix_en;
    logic [9:0]  r_h_cnt;
    logic [9:0]  r_v_cnt;
    logic        w_h_last;
    logic        w_v_last;
    logic        w_video_on;
    logic        w_hsync_raw;
    logic        w_vsync_raw;
    logic        w_vblank_next;
    logic [11:0] r_rgb;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_vblank_tick;

    // ------------------------------------------------------------------------
    // Pixel enable
    // ------------------------------------------------------------------------
`ifdef VGA_CLK_DIV_EN
    logic [1:0] r_div;

    // Free-running; the enable lands on the 4th clk after reset release so the
    // first pixel period is a full 4 clks long.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= 2'd0;
        end else begin
            r_div <= r_div + 2'd1;
        end
    end

    assign w_pix_en = (r_div == 2'd3);
`else
    assign w_pix_en = 1'b1;
`endif

    // ------------------------------------------------------------------------
    // Horizontal / vertical counters
    // ------------------------------------------------------------------------
    assign w_h_last = (r_h_cnt == c_h_last);
    assign w_v_last = (r_v_cnt == c_v_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_cnt <= 10'd0;
            r_v_cnt <= 10'd0;
        end else if (w_pix_en) begin
            if (w_h_last) begin
                r_h_cnt <= 10'd0;
                // The line wrap on the last line of the frame brings both
                // counters back to (0,0) in the same step.
                r_v_cnt <= w_v_last ? 10'd0 : r_v_cnt + 10'd1;
            end else begin
                r_h_cnt <= r_h_cnt + 10'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Visible region and coordinate bus
    // ------------------------------------------------------------------------
    assign w_video_on = (r_h_cnt < c_h_active) && (r_v_cnt < c_v_active);

    assign video_on = w_video_on;
    assign pix_x    = w_video_on ? r_h_cnt      : 10'd0;
    assign pix_y    = w_video_on ? r_v_cnt[8:0] : 9'd0;

    // ------------------------------------------------------------------------
    // Sync decode (active-low) and blank-entry detect
    // ------------------------------------------------------------------------
    assign w_hsync_raw = !((r_h_cnt >= c_h_sync_start) && (r_h_cnt <= c_h_sync_end));
    assign w_vsync_raw = !((r_v_cnt >= c_v_sync_start) && (r_v_cnt <= c_v_sync_end));

    // True on the pixel whose advance moves the counters to (0, V_ACTIVE).
    assign w_vblank_next = w_h_last && (r_v_cnt == c_v_last_vis);

    // ------------------------------------------------------------------------
    // Output pipeline: one register stage shared by colour, sync and tick so
    // that all pins describe the same counter position.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rgb         <= 12'd0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_vblank_tick <= 1'b0;
        end else if (w_pix_en) begin
            r_rgb         <= w_video_on ? rgb_in : 12'd0;
            r_hsync       <= w_hsync_raw;
            r_vsync       <= w_vsync_raw;
            r_vblank_tick <= w_vblank_next;
        end
    end

    assign vga_r       = r_rgb[11:8];
    assign vga_g       = r_rgb[7:4];
    assign vga_b       = r_rgb[3:0];
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign vblank_tick = r_vblank_tick;

endmodule
`default_nettype wire
